// File: rtl/imm_extend_pipe.sv
// Multi-mode immediate extender (sign/zero/upper/branch), registered behind a 2-entry skid buffer.
// Latency 1 cycle when empty; in_ready is registered (~skid valid). Optional out_trunc via IMM_EXTEND_PIPE_OVF_EN.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
`ifdef IMM_EXTEND_PIPE_OVF_EN
  ,
  output logic             out_trunc
`endif
);

  typedef struct packed {
`ifdef IMM_EXTEND_PIPE_OVF_EN
    logic             trunc;
`endif
    logic [1:0]       mode;
    logic [OUT_W-1:0] data;
  } ent_t;

  ent_t             new_ent;
  ent_t             out_q, out_d;
  ent_t             skid_q, skid_d;
  logic             out_vld_q, out_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             rdy_q, rdy_d;
  logic [OUT_W-1:0] sext;
  logic             in_fire;
  logic             out_fire;

`ifdef IMM_EXTEND_PIPE_OVF_EN
  // A branch offset loses information when its scaled value no longer fits IN_W signed bits.
  logic br_lost;
  if (IN_W > 2) begin : g_br_wide
    assign br_lost = (in_imm[IN_W-1] != in_imm[IN_W-3]) || (in_imm[IN_W-2] != in_imm[IN_W-3]);
  end else begin : g_br_narrow
    assign br_lost = |in_imm;
  end
`endif

  always_comb begin
    sext         = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    new_ent      = '0;
    new_ent.mode = in_mode;
    case (in_mode)
      2'b00:   new_ent.data = sext;
      2'b01:   new_ent.data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b10:   new_ent.data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default: new_ent.data = sext << 2;
    endcase
`ifdef IMM_EXTEND_PIPE_OVF_EN
    // The upper placement is exactly OUT_W wide, so only branch mode can lose bits.
    new_ent.trunc = (in_mode == 2'b11) && br_lost;
`endif
  end

  assign in_fire  = in_valid && rdy_q && !flush;
  assign out_fire = out_vld_q && out_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (out_fire) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (out_vld_q) begin
      if (in_fire && !out_fire) begin
        skid_d     = new_ent;
        skid_vld_d = 1'b1;
      end else if (in_fire) begin
        out_d = new_ent;
      end else if (out_fire) begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      out_d     = new_ent;
      out_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_q.data;
  assign out_mode  = out_q.mode;
`ifdef IMM_EXTEND_PIPE_OVF_EN
  assign out_trunc = out_q.trunc;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: scoreboard queue filled at input transfer, drained by an output monitor.
module tb_imm_extend_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic        out_trunc;

  logic        v12;
  logic        r12;
  logic [11:0] imm12;
  logic [1:0]  md12;
  logic        ov12;
  logic        ordy12;
  logic [15:0] od12;
  logic [1:0]  om12;
  logic        ot12;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    logic        trunc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
`ifdef IMM_EXTEND_PIPE_OVF_EN
    , .out_trunc(out_trunc)
`endif
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(16)) u12 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(v12), .in_ready(r12), .in_imm(imm12), .in_mode(md12),
    .out_valid(ov12), .out_ready(ordy12), .out_data(od12), .out_mode(om12)
`ifdef IMM_EXTEND_PIPE_OVF_EN
    , .out_trunc(ot12)
`endif
  );

`ifndef IMM_EXTEND_PIPE_OVF_EN
  assign out_trunc = 1'b0;
  assign ot12      = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted output must match the oldest expected entry.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", out_data, 32'hDEAD_DEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_mode", {30'd0, out_mode}, {30'd0, e.mode});
`ifdef IMM_EXTEND_PIPE_OVF_EN
        chk("out_trunc", {31'd0, out_trunc}, {31'd0, e.trunc});
`endif
      end
    end
  end

  task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                      input logic [31:0] d, input logic t);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      e.data = d; e.mode = mode; e.trunc = t;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    v12 = 1'b0; imm12 = '0; md12 = '0; ordy12 = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_mode", {30'd0, out_mode}, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rdy_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", {31'd0, in_ready}, 32'd1);

    // Basic sign extension and one-cycle latency
    out_ready = 1'b1;
    send(16'h0AC1, 2'b00, 32'h0000_0AC1, 1'b0);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    send(16'hEA81, 2'b00, 32'hFFFF_EA81, 1'b0);
    send(16'hC000, 2'b01, 32'h0000_C000, 1'b0);
    send(16'hC000, 2'b10, 32'hC000_0000, 1'b0);
    send(16'hC000, 2'b11, 32'hFFFF_0000, 1'b1);
    send(16'h4000, 2'b11, 32'h0001_0000, 1'b1);
    send(16'h0001, 2'b11, 32'h0000_0004, 1'b0);
    drain();

    // Narrow instance: 12 -> 16
    chk("w12_ready", {31'd0, r12}, 32'd1);
    v12 = 1'b1; imm12 = 12'h800; md12 = 2'b00;
    @(posedge clk); #1;
    chk("w12_valid", {31'd0, ov12}, 32'd1);
    chk("w12_sign", {16'd0, od12}, 32'h0000_F800);
    md12 = 2'b10; imm12 = 12'hABC;
    @(posedge clk); #1;
    v12 = 1'b0;
    chk("w12_upper", {16'd0, od12}, 32'h0000_ABC0);
    chk("w12_mode", {30'd0, om12}, 32'd2);
    @(posedge clk); #1;
    chk("w12_idle", {31'd0, ov12}, 32'd0);

    // Backpressure: fill both entries, third input must wait
    out_ready = 1'b0;
    send(16'h0001, 2'b00, 32'h0000_0001, 1'b0);
    send(16'h0002, 2'b00, 32'h0000_0002, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_imm = 16'h0003; in_mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_data", out_data, 32'h0000_0001);
    end
    out_ready = 1'b1;
    send(16'h0003, 2'b00, 32'h0000_0003, 1'b0);
    drain();

    // Flush while FULL with an input offered
    out_ready = 1'b0;
    send(16'h0010, 2'b01, 32'h0000_0010, 1'b0);
    send(16'h0020, 2'b01, 32'h0000_0020, 1'b0);
    in_valid = 1'b1; in_imm = 16'h0030; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    out_ready = 1'b1;
    // Flush while empty drops an input even though in_ready is high
    in_valid = 1'b1; in_imm = 16'h0040; in_mode = 2'b01; flush = 1'b1;
    chk("flush_empty_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_v0", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_drop_v1", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges while FULL
    out_ready = 1'b0;
    send(16'h0050, 2'b00, 32'h0000_0050, 1'b0);
    send(16'h0060, 2'b00, 32'h0000_0060, 1'b0);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    sb.delete();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    send(16'h8000, 2'b00, 32'hFFFF_8000, 1'b0);
    send(16'h8000, 2'b01, 32'h0000_8000, 1'b0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
